// File: rtl/sliding_window_accumulator.sv
// ---------------------------------------------------------------------------
// sliding_window_accumulator
//
// Running sum (or mean) of the most recent L = 2^win_log2 accepted samples.
// A circular history buffer holds past samples.  A single accumulator adds
// each new sample and subtracts the sample that leaves the window, so no
// adder tree is needed.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clr          synchronous flush of window state
//   in_valid     in_data carries a new sample this cycle
//   in_data      sample (two's complement when signed_mode=1)
//   win_log2     window length select; values above DEPTH_LOG2 are clamped
//   signed_mode  1 = signed samples / arithmetic shift, 0 = unsigned
//   avg_mode     1 = output sum >> win, 0 = raw sum
//   out_valid    out_data / out_full were updated this cycle
//   out_data     window sum or mean, OW bits
//   out_full     window holds L samples since the last flush
// ---------------------------------------------------------------------------
module sliding_window_accumulator #(
    parameter int DW         = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int OW         = DW + DEPTH_LOG2,
    parameter int WSW        = $clog2(DEPTH_LOG2 + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    input  logic [WSW-1:0] win_log2,
    input  logic           signed_mode,
    input  logic           avg_mode,
    output logic           out_valid,
    output logic [OW-1:0]  out_data,
    output logic           out_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int FW    = DEPTH_LOG2 + 1;   // fill counter reaches DEPTH

    // History buffer: contents are don't-care after reset, so no reset.
    logic [DW-1:0] hist_mem [DEPTH];

    logic [OW-1:0]         acc_q, acc_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [FW-1:0]         fill_q, fill_d;
    logic [WSW-1:0]        win_q, win_d;
    logic                  signed_q, signed_d;
    logic                  out_valid_q, out_valid_d;
    logic [OW-1:0]         out_data_q, out_data_d;
    logic                  out_full_q, out_full_d;

    logic [WSW-1:0]        win_clamped;
    logic                  flush;
    logic [FW-1:0]         len_q, len_d;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DW-1:0]         oldest;
    logic [OW-1:0]         avg_val;

    function automatic logic [OW-1:0] ext(input logic [DW-1:0] s, input logic sgn);
        return sgn ? {{(OW-DW){s[DW-1]}}, s} : {{(OW-DW){1'b0}}, s};
    endfunction

    always_comb begin
        win_clamped = (win_log2 > WSW'(DEPTH_LOG2)) ? WSW'(DEPTH_LOG2) : win_log2;
        flush       = clr || (win_clamped != win_q) || (signed_mode != signed_q);

        acc_d       = acc_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        win_d       = win_clamped;   // equal to win_q unless a flush occurs
        signed_d    = signed_mode;   // equal to signed_q unless a flush occurs
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_full_d  = out_full_q;
        oldest      = '0;
        avg_val     = '0;

        len_q  = FW'(1) << win_q;
        len_d  = FW'(1) << win_d;
        // For L = DEPTH the truncated length is 0, so rd_idx == wptr_q: the
        // entry about to be overwritten, read before the write lands.
        rd_idx = wptr_q - len_q[DEPTH_LOG2-1:0];

        if (flush) begin
            acc_d  = '0;
            fill_d = '0;
        end

        if (in_valid) begin
            // The sample is always stored, even on a flush, because it is
            // the first member of the new window and must be subtracted
            // later when it ages out.
            wptr_d = wptr_q + DEPTH_LOG2'(1);
            if (flush) begin
                acc_d  = ext(in_data, signed_d);
                fill_d = FW'(1);
            end else begin
                if (fill_q == len_q) begin
                    oldest = hist_mem[rd_idx];
                end
                acc_d  = acc_q + ext(in_data, signed_q) - ext(oldest, signed_q);
                fill_d = (fill_q == len_q) ? fill_q : fill_q + FW'(1);
            end

            if (signed_d) begin
                avg_val = OW'($signed(acc_d) >>> win_d);
            end else begin
                avg_val = acc_d >> win_d;
            end

            out_valid_d = 1'b1;
            out_data_d  = avg_mode ? avg_val : acc_d;
            out_full_d  = (fill_d == len_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            win_q       <= '0;
            signed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            win_q       <= win_d;
            signed_q    <= signed_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_full_q  <= out_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            hist_mem[wptr_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_sliding_window_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sliding_window_accumulator
//
// Directed stimulus with hand-computed expectations.  Each issued sample
// pushes its expected {out_data, out_full} into a queue; a monitor process
// pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_sliding_window_accumulator;

    localparam int DW = 8;
    localparam int DL = 4;
    localparam int OW = DW + DL;
    localparam int WSW = $clog2(DL + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clr = 1'b0;
    logic           in_valid = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic [WSW-1:0] win_log2 = '0;
    logic           signed_mode = 1'b0;
    logic           avg_mode = 1'b0;
    logic           out_valid;
    logic [OW-1:0]  out_data;
    logic           out_full;

    // Configuration applied together with the next issued cycle.
    logic [WSW-1:0] cfg_win = '0;
    logic           cfg_sgn = 1'b0;
    logic           cfg_avg = 1'b0;

    typedef struct {
        logic [OW-1:0] d;
        logic          f;
    } exp_t;
    exp_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    sliding_window_accumulator #(.DW(DW), .DEPTH_LOG2(DL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .win_log2   (win_log2),
        .signed_mode(signed_mode),
        .avg_mode   (avg_mode),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_full   (out_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one cycle; valid=1 pushes the expected response.
    task automatic issue(input logic v, input logic c, input logic [DW-1:0] d,
                         input logic [OW-1:0] e_d, input logic e_f);
        exp_t e;
        @(negedge clk);
        win_log2    = cfg_win;
        signed_mode = cfg_sgn;
        avg_mode    = cfg_avg;
        in_valid    = v;
        clr         = c;
        in_data     = d;
        if (v) begin
            e.d = e_d;
            e.f = e_f;
            exp_q.push_back(e);
            $display("issue data=%0h exp_out=%0h exp_full=%0b", d, e_d, e_f);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] e_d, input logic e_f);
        issue(1'b1, 1'b0, d, e_d, e_f);
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Monitor: compare each presented output against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("out data=%0h full=%0b", out_data, out_full);
                    check("out_data", 32'(out_data), 32'(e.d));
                    check("out_full", 32'(out_full), 32'(e.f));
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_full", 32'(out_full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned, L=4
        cfg_win = 3'd2;
        send(8'd1, 12'd1, 1'b0);
        send(8'd2, 12'd3, 1'b0);
        send(8'd3, 12'd6, 1'b0);
        send(8'd4, 12'd10, 1'b1);
        send(8'd5, 12'd14, 1'b1);
        send(8'd6, 12'd18, 1'b1);
        // Window change with a concurrent sample: flush, new window L=2
        cfg_win = 3'd1;
        send(8'd9, 12'd9, 1'b0);
        send(8'd1, 12'd10, 1'b1);
        send(8'd3, 12'd4, 1'b1);   // 10 + 3 - 9

        // Gap handling after a standalone clr, L=2
        issue(1'b0, 1'b1, '0, '0, 1'b0);
        send(8'd2, 12'd2, 1'b0);
        idle();
        @(posedge clk); #1;
        check("gap_valid_1", 32'(out_valid), 32'd0);
        check("gap_hold_1", 32'(out_data), 32'd2);
        idle();
        @(posedge clk); #1;
        check("gap_valid_2", 32'(out_valid), 32'd0);
        check("gap_hold_2", 32'(out_data), 32'd2);
        send(8'd4, 12'd6, 1'b1);

        // Signed, L=2, raw sum
        cfg_sgn = 1'b1;
        send(8'hFF, 12'hFFF, 1'b0);
        send(8'hFE, 12'hFFD, 1'b1);
        send(8'h05, 12'h003, 1'b1);
        // Same samples averaged, restarted with clr + sample
        cfg_avg = 1'b1;
        issue(1'b1, 1'b1, 8'hFF, 12'hFFF, 1'b0);
        send(8'hFE, 12'hFFE, 1'b1);
        send(8'h05, 12'h001, 1'b1);

        // Unsigned, win_log2=7 clamped to L=16, 20 samples of 0x80
        cfg_sgn = 1'b0;
        cfg_avg = 1'b0;
        cfg_win = 3'd7;
        for (int k = 1; k <= 20; k++) begin
            send(8'h80, (k >= 16) ? 12'h800 : 12'(k * 128), k >= 16);
        end

        // Asynchronous reset away from any clock edge
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_full", 32'(out_full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd7, 12'd7, 1'b0);
        send(8'd1, 12'd8, 1'b0);

        // Drain with a bounded wait
        idle();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
